// File: rtl/shift_seq_pkg.sv
// Shared state encoding and sizing helper for the shift sequencing controller.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE,
        ST_GAP
    } state_e;

    // Bits needed to hold any value 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_seq_gap_cnt.sv
// Idle-gap down-counter; zero marks the final gap cycle.
module shift_seq_gap_cnt
    import shift_seq_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int GW = cnt_width(GAP);

    logic [GW-1:0] cnt_q, cnt_d;

    // Loaded with GAP-1 so that zero is already high during the last gap cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = GW'(GAP - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - GW'(1);
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serializes a parallel word MSB first into a downstream shift register, pulses done, then idles GAP cycles.
// Optional macro SHIFT_SEQ_CTRL_PARITY_EN appends an even-parity bit after in_data[0].
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = cnt_width(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             in_ready_q, in_ready_d;
    logic             ser_out_q, ser_out_d;
    logic             shift_en_q, shift_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             gap_load, gap_dec, gap_zero;

    // Serial bit for position idx of the outgoing stream (MSB first, parity last).
    function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
        logic [WIDTH-1:0] sh;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        if (idx == CW'(WIDTH)) return ^w;
`endif
        sh = w << idx;
        return sh[WIDTH-1];
    endfunction

    generate
        if (GAP > 0) begin : g_gap
            shift_seq_gap_cnt #(.GAP(GAP)) u_gap_cnt (
                .clock (clock),
                .clear (clear),
                .load  (gap_load),
                .dec   (gap_dec),
                .zero  (gap_zero)
            );
        end else begin : g_no_gap
            logic gap_unused;
            assign gap_unused = gap_load | gap_dec;
            assign gap_zero   = 1'b1;
        end
    endgenerate

    // Outputs are computed for the next cycle so every port comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        in_ready_d = 1'b0;
        ser_out_d  = 1'b0;
        shift_en_d = 1'b0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = ST_SHIFT;
                    hold_d     = in_data;
                    cnt_d      = '0;
                    shift_en_d = 1'b1;
                    ser_out_d  = bit_at(in_data, '0);
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    shift_en_d = 1'b1;
                    ser_out_d  = bit_at(hold_q, cnt_q + CW'(1));
                end
            end
            ST_DONE: begin
                if (GAP > 0) begin
                    state_d  = ST_GAP;
                    gap_load = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_zero) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            in_ready_q <= 1'b0;
            ser_out_q  <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            in_ready_q <= in_ready_d;
            ser_out_q  <= ser_out_d;
            shift_en_q <= shift_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign in_ready = in_ready_q;
    assign ser_out  = ser_out_q;
    assign shift_en = shift_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: driver queues expected word outcomes, monitor checks them against the serial stream.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int GAP   = 1;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             abort = 1'b0;
    logic             in_ready, ser_out, shift_en, busy, done, aborted;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        bit            is_done;
        int            nbits;
        logic [31:0]   bits;
        int            lat;
        int            rdy;
        int            hs;
        logic [NB-1:0] dreg;
    } exp_t;

    exp_t q[$];

    shift_seq_ctrl #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clock    (clock),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .abort    (abort),
        .ser_out  (ser_out),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Downstream register: stage 0 takes the serial input, stage NB-1 is the last stage.
    logic [NB-1:0] dreg;
    always @(posedge clock) if (shift_en) dreg <= {dreg[NB-2:0], ser_out};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Bit stream the register should see, element i = i-th bit sent.
    function automatic logic [31:0] ref_stream(input logic [WIDTH-1:0] w);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) s[i] = w[WIDTH-1-i];
        if (NB > WIDTH) s[WIDTH] = ^w;
        return s;
    endfunction

    // After a full word the first bit sent sits in the last stage.
    function automatic logic [NB-1:0] ref_reg(input logic [WIDTH-1:0] w);
        logic [31:0]   s;
        logic [NB-1:0] r;
        s = ref_stream(w);
        for (int i = 0; i < NB; i++) r[NB-1-i] = s[i];
        return r;
    endfunction

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_ser_out"},  32'(ser_out),  32'd0);
        chk({tag, "_shift_en"}, 32'(shift_en), 32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_aborted"},  32'(aborted),  32'd0);
    endtask

    // Monitor
    int          nsh = 0;
    logic [31:0] col = '0;
    int          ready_due = -1;
    always @(negedge clock) begin
        exp_t e;
        if (clear) begin
            nsh = 0;
            col = '0;
            ready_due = -1;
        end else begin
            if (shift_en) begin
                if (nsh < 32) col[nsh] = ser_out;
                nsh++;
            end else begin
                chk("ser_out_idle", 32'(ser_out), 32'd0);
            end
            if (shift_en || done) chk("busy_active", 32'(busy), 32'd1);
            if (ready_due >= 0) begin
                if (cyc == ready_due) begin
                    chk("ready_return", 32'(in_ready), 32'd1);
                    ready_due = -1;
                end else begin
                    chk("ready_held_low", 32'(in_ready), 32'd0);
                end
            end
            if (done || aborted) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", 32'(done), 32'(e.is_done));
                    chk("done_and_aborted", 32'(done & aborted), 32'd0);
                    chk("shift_count", 32'(nsh), 32'(e.nbits));
                    chk("serial_bits", col, e.bits);
                    chk("event_latency", 32'(cyc - e.hs), 32'(e.lat));
                    if (done) chk("register_contents", 32'(dreg), 32'(e.dreg));
                    ready_due = cyc + e.rdy;
                end
                nsh = 0;
                col = '0;
            end
        end
    end

    // Driver: called at a negedge; returns at the negedge inside the first shift cycle (or after the abort pulse).
    task automatic send(input logic [WIDTH-1:0] w, input int abort_k, input bit idle_abort,
                        input bit keep_valid, output int hs);
        exp_t        e;
        int          guard;
        logic [31:0] s;
        if (idle_abort) begin
            in_valid = 1'b0;
            guard = 0;
            while (!in_ready && guard < 60) begin @(negedge clock); guard++; end
            abort = 1'b1;
            @(negedge clock);
            abort = 1'b0;
            chk("idle_abort_ready", 32'(in_ready), 32'd1);
            chk("idle_abort_pulse", 32'(aborted), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = w;
        guard = 0;
        while (!in_ready && guard < 60) begin @(negedge clock); guard++; end
        chk("handshake_wait", 32'(in_ready), 32'd1);
        s = ref_stream(w);
        e.is_done = (abort_k == 0);
        e.nbits   = (abort_k == 0) ? NB : abort_k;
        e.bits    = (abort_k == 0) ? s : (s & ((32'd1 << abort_k) - 32'd1));
        e.lat     = (abort_k == 0) ? NB : abort_k;
        e.rdy     = (abort_k == 0) ? GAP + 1 : 1;
        e.hs      = cyc + 1;
        e.dreg    = ref_reg(w);
        hs        = e.hs;
        q.push_back(e);
        @(negedge clock);
        if (!keep_valid) in_valid = 1'b0;
        if (abort_k > 0) begin
            repeat (abort_k - 1) @(negedge clock);
            abort = 1'b1;
            @(negedge clock);
            abort = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs1, hs2, guard;
        #1 clear = 1'b1;
        #2 chk_outs_zero("reset");
        repeat (2) @(negedge clock);
        #2 clear = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        send(4'b1011, 0, 1'b0, 1'b0, hs1);

        send(4'hF, 0, 1'b0, 1'b1, hs1);
        send(4'h0, 0, 1'b0, 1'b0, hs2);
        chk("back_to_back_spacing", 32'(hs2 - hs1), 32'(NB + 2 + GAP));

        send(4'hA, 2, 1'b0, 1'b0, hs1);
        send(4'h5, NB, 1'b0, 1'b0, hs1);
        send(4'b0111, 0, 1'b1, 1'b0, hs1);

        send(4'b1100, 0, 1'b0, 1'b0, hs1);
        @(negedge clock);
        #2 clear = 1'b1;
        #1 chk_outs_zero("clear_mid_shift");
        q.delete();
        @(negedge clock);
        #2 clear = 1'b0;
        @(negedge clock);
        chk("ready_after_clear", 32'(in_ready), 32'd1);
        send(4'b0110, 0, 1'b0, 1'b0, hs1);

        for (int i = 0; i < 40; i++) begin
            int ab;
            bit keep;
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NB)) : 0;
            keep = 1'($urandom_range(0, 1));
            send(WIDTH'($urandom), ab, ($urandom_range(0, 4) == 0), keep, hs1);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        in_valid = 1'b0;
        guard = 0;
        while ((q.size() != 0 || ready_due >= 0) && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
